alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
- Execute-stage controller directly upstream of the 8-bit ALU (4-bit opcode, inputs a/b, output y).
- Accepts one ALU request through a valid/ready handshake and drives the ALU's opcode, a and b inputs.
- Registers the ALU result into an accumulator and computes 8085-style flags.
- Returns the result, flags and an error bit through a valid/ready response handshake.

Parameters:
- ACC_INIT, 8'h00, accumulator value loaded on reset.
- SETTLE_CYC, 0, extra wait cycles between driving the ALU and capturing its output (0..15).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  4  ALU opcode: 0 OR, 1 AND, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 TX, 7 RSHIFTN
- req_use_acc  in  1  1: ALU a = accumulator; 0: ALU a = req_a
- req_a  in  8  a operand
- req_b  in  8  b operand
- alu_opcode  out  4  to ALU opcode
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_y  in  8  ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  8  captured result
- rsp_flags  out  5  {S,Z,AC,P,CY}
- rsp_err  out  1  illegal opcode
- acc_out  out  8  current accumulator

Behaviour:
- Reset values:
  - state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_flags=0; rsp_err=0.
  - acc=ACC_INIT; alu_opcode=0; alu_a=0; alu_b=0.
- States:
  - IDLE -> ISSUE on req_valid&&req_ready.
  - ISSUE -> WAIT if SETTLE_CYC>0, else CAPTURE.
  - WAIT -> CAPTURE after SETTLE_CYC cycles (4-bit down-counter).
  - CAPTURE -> RESP.
  - RESP -> IDLE on rsp_ready.
- Request acceptance:
  - req_ready=1 only in IDLE.
  - On accept, latch op, a and b. a = acc when req_use_acc=1, otherwise req_a.
- ALU drive:
  - alu_opcode, alu_a and alu_b are registered and stay stable from ISSUE through CAPTURE.
  - They hold their last values in RESP and IDLE.
- CAPTURE (one cycle): register alu_y into rsp_data and compute flags from the captured y and the latched a and b:
  - S = y[7]; Z = (y==0); P = ~^y (1 = even parity).
  - CY, ADD: carry out of the 9-bit sum a+b.
  - CY, SUB: borrow (a<b).
  - CY, RSHIFTN: 0 if b==0 or b>8, otherwise a[b-1].
  - CY, OR/AND/NOT/XOR: cleared.
  - TX: all five flags unchanged from the previous response.
- acc update: written with y in CAPTURE for legal opcodes 0-7.
- Illegal opcode (8-15):
  - No ALU dependency; the controller does not sample alu_y.
  - rsp_err=1, rsp_data=0, acc and flags unchanged.
  - Still passes through ISSUE, WAIT and CAPTURE with the same latency.
- Response:
  - rsp_valid=1 in RESP only.
  - rsp_data, rsp_flags and rsp_err stay stable until the rsp_ready handshake, and hold afterwards.
- Latency: accept to rsp_valid = 3+SETTLE_CYC cycles. Minimum initiation interval = 4+SETTLE_CYC cycles with rsp_ready held high.
- rsp_ready low: state stays RESP indefinitely and no new request is accepted (req_ready=0).
- req_valid asserted outside IDLE: ignored. The requester must hold the request until accepted.
- Reset mid-operation: asynchronous return to the reset values. No response is emitted for the in-flight request.

Optional Feature:
- Macro AUX_CARRY_EN.
- Defined: AC = carry out of bit 3.
  - ADD: AC = carry out of a[3:0]+b[3:0].
  - SUB: AC = borrow, a[3:0]<b[3:0].
  - AND: AC = 1.
  - Other legal ops: AC = 0.
  - TX: AC unchanged.
- Not defined: rsp_flags[2] is tied 0 and no half-carry logic is built.

Test Plan:
- Reset, then ADD: req_use_acc=0, a=8'hF0, b=8'h20, SETTLE_CYC=0 -> rsp_valid 3 cycles after accept; rsp_data=8'h10; S=0, Z=0, P=0, CY=1; acc_out=8'h10.
- SUB with req_use_acc=1 after the previous ADD (acc=8'h10), b=8'h10 -> rsp_data=8'h00; Z=1, P=1, CY=0; with AUX_CARRY_EN, AC=0.
- RSHIFTN: a=8'b0000_0110, b=2 -> rsp_data=8'h01, CY=1. Repeat with b=9 -> rsp_data=8'h00, CY=0, Z=1.
- Illegal opcode 4'hA after a response carrying CY=1 -> rsp_err=1, rsp_data=0, flags and acc unchanged, latency unchanged. TX of 8'h80 -> acc=8'h80, flags unchanged.
- Back-pressure with SETTLE_CYC=2: rsp_ready low for 5 cycles -> rsp outputs stable, req_ready=0 throughout. Then rsp_ready high -> IDLE the next cycle and the next request is accepted.
- Assert rst_n low during WAIT -> outputs immediately at reset values, acc=ACC_INIT, no rsp_valid pulse.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller driving an external 8-bit ALU; optional half-carry flag under AUX_CARRY_EN
module alu_exec_ctrl #(
  parameter logic [7:0] ACC_INIT   = 8'h00,
  parameter int         SETTLE_CYC = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic       req_use_acc,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [4:0] rsp_flags,
  output logic       rsp_err,
  output logic [7:0] acc_out
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [7:0] acc;
  logic [8:0] sum9;
  logic [2:0] sh;
  logic       legal, cy, ac;
  logic [4:0] flags_nx;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign acc_out   = acc;
  assign legal     = ~alu_opcode[3];
  assign sum9      = {1'b0, alu_a} + {1'b0, alu_b};
  assign sh        = alu_b[2:0] - 3'd1;
  assign cy        = alu_opcode == 4'd4 ? sum9[8] :
                     alu_opcode == 4'd5 ? alu_a < alu_b :
                     alu_opcode == 4'd7 ? (alu_b != 8'd0 && alu_b <= 8'd8 && alu_a[sh]) : 1'b0;
`ifdef AUX_CARRY_EN
  logic [4:0] hsum;
  assign hsum = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]};
  assign ac   = alu_opcode == 4'd4 ? hsum[4] :
                alu_opcode == 4'd5 ? alu_a[3:0] < alu_b[3:0] :
                alu_opcode == 4'd1;
`else
  assign ac = 1'b0;
`endif
  assign flags_nx = {alu_y[7], alu_y == 8'd0, ac, ~^alu_y, cy};
  // next-state: WAIT only exists when the ALU needs settle time
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? ISSUE : IDLE;
      ISSUE:   state_nx = SETTLE_CYC > 0 ? WAIT : CAPTURE;
      WAIT:    state_nx = cnt == 4'd0 ? CAPTURE : WAIT;
      CAPTURE: state_nx = RESP;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // state register and settle down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= state == ISSUE ? SETTLE_LD : state == WAIT ? cnt - 4'd1 : cnt;
    end
  end
  // operand latch on accept; result, flags and accumulator capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= 4'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      acc        <= ACC_INIT;
      rsp_data   <= 8'd0;
      rsp_flags  <= 5'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        alu_opcode <= req_op;
        alu_a      <= req_use_acc ? acc : req_a;
        alu_b      <= req_b;
      end
      if (state == CAPTURE) begin
        rsp_err  <= ~legal;
        rsp_data <= legal ? alu_y : 8'd0;
        if (legal) acc <= alu_y;
        if (legal && alu_opcode != 4'd6) rsp_flags <= flags_nx;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: random and directed checks of two controllers (settle 0 and 2) against a reference model
module tb_alu_exec_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, req_valid, req_use_acc, rsp_ready;
  logic [3:0] req_op;
  logic [7:0] req_a, req_b;
  logic       req_ready[2], rsp_valid[2], rsp_err[2];
  logic [3:0] alu_opcode[2];
  logic [7:0] alu_a[2], alu_b[2], alu_y[2], rsp_data[2], acc_out[2];
  logic [4:0] rsp_flags[2];
  logic [7:0] acc_m;
  logic [4:0] flags_m;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0: return a | b;
      4'd1: return a & b;
      4'd2: return ~a;
      4'd3: return a ^ b;
      4'd4: return a + b;
      4'd5: return a - b;
      4'd6: return a;
      4'd7: return a >> b;
      default: return 8'hA5;
    endcase
  endfunction

  function automatic logic [4:0] flags_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] y, input logic [4:0] prev);
    int ai = a, bi = b, cy = 0, ac = 0;
    logic s, z, p;
    if (op == 4'd6) return prev;
    if (op == 4'd4) cy = (ai + bi > 255) ? 1 : 0;
    if (op == 4'd5) cy = (ai < bi) ? 1 : 0;
    if (op == 4'd7 && bi >= 1 && bi <= 8) cy = (ai >> (bi - 1)) % 2;
`ifdef AUX_CARRY_EN
    if (op == 4'd4) ac = (ai % 16 + bi % 16 > 15) ? 1 : 0;
    if (op == 4'd5) ac = (ai % 16 < bi % 16) ? 1 : 0;
    if (op == 4'd1) ac = 1;
`endif
    s = y >= 8'd128;
    z = y == 8'd0;
    p = $countones(y) % 2 == 0;
    return {s, z, ac[0], p, cy[0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_exec_ctrl #(.ACC_INIT(8'h3C), .SETTLE_CYC(2 * g)) u (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready[g]), .req_op(req_op),
      .req_use_acc(req_use_acc), .req_a(req_a), .req_b(req_b),
      .alu_opcode(alu_opcode[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_y(alu_y[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[g]),
      .rsp_flags(rsp_flags[g]), .rsp_err(rsp_err[g]), .acc_out(acc_out[g])
    );
    assign alu_y[g] = alu_f(alu_opcode[g], alu_a[g], alu_b[g]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_rst_rdy", g), req_ready[g], 1);
      chk($sformatf("d%0d_rst_vld", g), rsp_valid[g], 0);
      chk($sformatf("d%0d_rst_data", g), rsp_data[g], 0);
      chk($sformatf("d%0d_rst_flags", g), rsp_flags[g], 0);
      chk($sformatf("d%0d_rst_err", g), rsp_err[g], 0);
      chk($sformatf("d%0d_rst_acc", g), acc_out[g], 8'h3C);
      chk($sformatf("d%0d_rst_alu", g), {alu_opcode[g], alu_a[g], alu_b[g]}, 0);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic use_acc, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [7:0] ae, ye;
    logic [4:0] fe;
    logic       erre;
    bit         seen[2] = '{0, 0};
    int         n = 0;
    ae   = use_acc ? acc_m : a;
    erre = op >= 4'd8;
    ye   = erre ? 8'd0 : alu_f(op, ae, b);
    fe   = erre ? flags_m : flags_f(op, ae, b, ye, flags_m);
    @(negedge clk);
    req_op = op; req_use_acc = use_acc; req_a = a; req_b = b; req_valid = 1'b1;
    rsp_ready = hold == 0;
    for (int g = 0; g < 2; g++) chk($sformatf("d%0d_rdy", g), req_ready[g], 1);
    while (!(seen[0] && seen[1]) && n < 40) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      for (int g = 0; g < 2; g++)
        if (rsp_valid[g] && !seen[g]) begin
          seen[g] = 1;
          chk($sformatf("d%0d_lat op%0h", g, op), n, 3 + 2 * g);
          chk($sformatf("d%0d_data op%0h", g, op), rsp_data[g], ye);
          chk($sformatf("d%0d_flags op%0h", g, op), rsp_flags[g], fe);
          chk($sformatf("d%0d_err op%0h", g, op), rsp_err[g], erre);
          chk($sformatf("d%0d_acc op%0h", g, op), acc_out[g], erre ? acc_m : ye);
        end
    end
    for (int g = 0; g < 2; g++) if (!seen[g]) chk($sformatf("d%0d_timeout", g), 0, 1);
    repeat (hold) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("d%0d_bp_vld", g), rsp_valid[g], 1);
        chk($sformatf("d%0d_bp_rdy", g), req_ready[g], 0);
        chk($sformatf("d%0d_bp_rsp", g), {rsp_data[g], rsp_flags[g], rsp_err[g]}, {ye, fe, erre});
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_end_vld", g), rsp_valid[g], 0);
      chk($sformatf("d%0d_end_rdy", g), req_ready[g], 1);
    end
    if (!erre) begin
      acc_m   = ye;
      flags_m = fe;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_use_acc = 1'b0; rsp_ready = 1'b1;
    req_op = 4'd0; req_a = 8'd0; req_b = 8'd0;
    acc_m = 8'h3C; flags_m = 5'd0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    run(4'd4, 1'b0, 8'hF0, 8'h20, 0);
    run(4'd5, 1'b1, 8'h00, 8'h10, 0);
    run(4'd7, 1'b0, 8'h06, 8'd2, 0);
    run(4'd7, 1'b0, 8'h06, 8'd9, 0);
    run(4'd4, 1'b0, 8'hFF, 8'h01, 0);
    run(4'hA, 1'b0, 8'h12, 8'h34, 0);
    run(4'd6, 1'b0, 8'h80, 8'h00, 0);
    run(4'd1, 1'b1, 8'h00, 8'hC3, 5);
    run(4'd0, 1'b0, 8'h00, 8'h00, 0);
    @(negedge clk);
    req_op = 4'd4; req_use_acc = 1'b0; req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (4) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) chk($sformatf("d%0d_rst_novld", g), rsp_valid[g], 0);
    end
    rst_n = 1'b1;
    acc_m = 8'h3C; flags_m = 5'd0;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [7:0] b;
      op = 4'($urandom_range(0, 11));
      b  = op == 4'd7 ? 8'($urandom_range(0, 10)) : 8'($urandom);
      run(op, 1'($urandom), 8'($urandom), b, $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
